// File: rtl/tag_scan_pkg.sv
// Shared types and widths for the tag scan sequencer.
// Imported by the sequencer top and its countdown helper.
package tag_scan_pkg;

    localparam int CHANNEL_W = 5;
    localparam int DWELL_W   = 16;
    localparam int RESULT_W  = 31;
    localparam int CNT_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        DWELL,
        CHECK,
        REPORT
    } scan_state_t;

endpackage

// File: rtl/scan_cycle_counter.sv
// Loadable down-counter used for the HOLD and CHECK countdowns.
// zero is high once the loaded count has run out.
module scan_cycle_counter
    import tag_scan_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    // load wins over enable; counting stops at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/tag_scan_sequencer.sv
// Walks a channel range, settling, dwelling and sampling the
// interval checker on each channel, and reports per-channel results.
module tag_scan_sequencer
    import tag_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8,
    parameter int CHECK_DELAY   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [4:0]  chan_first,
    input  logic [4:0]  chan_last,
    input  logic [15:0] dwell_tags,
    input  logic        valid_tag,
    input  logic [4:0]  channel,
    input  logic [31:0] chk_failed,
    output logic        chk_hold,
    output logic [4:0]  chk_channel_select,
    output logic        busy,
    output logic        done,
    output logic [31:0] fail_mask,
    output logic        result_valid,
    output logic [4:0]  result_channel,
    output logic [30:0] result_time
);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CHECK_LD  = CNT_W'(CHECK_DELAY - 1);

    scan_state_t state;
    scan_state_t state_nxt;

    logic [CHANNEL_W-1:0] cur;
    logic [CHANNEL_W-1:0] last_ch;
    logic [DWELL_W-1:0]   dwell_cnt;
    logic [DWELL_W-1:0]   dwell_tgt;
    logic [DWELL_W-1:0]   dwell_inc;

    logic             cnt_load;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;

    logic abort_hit;
    logic start_scan;
    logic empty_scan;
    logic finish;
    logic next_ch;
    logic take_sample;
    logic dwell_step;
    logic tag_hit;

    assign tag_hit   = valid_tag && (channel == cur);
    assign dwell_inc = dwell_cnt + DWELL_W'(1);
    assign abort_hit = abort && (state != IDLE);

    scan_cycle_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and per-cycle control strobes
    always_comb begin
        state_nxt   = state;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        cnt_val     = '0;
        start_scan  = 1'b0;
        empty_scan  = 1'b0;
        finish      = 1'b0;
        next_ch     = 1'b0;
        take_sample = 1'b0;
        dwell_step  = 1'b0;
        if (abort_hit) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        if (chan_first <= chan_last) begin
                            state_nxt  = HOLD;
                            start_scan = 1'b1;
                            cnt_load   = 1'b1;
                            cnt_val    = SETTLE_LD;
                        end else begin
                            empty_scan = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (cnt_zero) begin
                        state_nxt = DWELL;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                DWELL: begin
                    if (tag_hit) begin
                        dwell_step = 1'b1;
                        if (dwell_inc == dwell_tgt) begin
                            state_nxt = CHECK;
                            cnt_load  = 1'b1;
                            cnt_val   = CHECK_LD;
                        end
                    end
                end
                CHECK: begin
                    if (cnt_zero) begin
                        state_nxt   = REPORT;
                        take_sample = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                REPORT: begin
                    if (cur == last_ch) begin
                        state_nxt = IDLE;
                        finish    = 1'b1;
                    end else begin
                        state_nxt = HOLD;
                        next_ch   = 1'b1;
                        cnt_load  = 1'b1;
                        cnt_val   = SETTLE_LD;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // scan bookkeeping, dwell count and registered result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur            <= '0;
            last_ch        <= '0;
            dwell_cnt      <= '0;
            dwell_tgt      <= '0;
            done           <= 1'b0;
            fail_mask      <= '0;
            result_valid   <= 1'b0;
            result_channel <= '0;
            result_time    <= '0;
        end else begin
            done         <= abort_hit || empty_scan || finish;
            result_valid <= take_sample;
            if (start_scan) begin
                cur       <= chan_first;
                last_ch   <= chan_last;
                fail_mask <= '0;
                dwell_cnt <= '0;
                dwell_tgt <= (dwell_tags == '0) ? DWELL_W'(1) : dwell_tags;
            end
            if (empty_scan) begin
                fail_mask <= '0;
            end
            if (next_ch) begin
                cur       <= cur + CHANNEL_W'(1);
                dwell_cnt <= '0;
            end
            if (dwell_step) begin
                dwell_cnt <= dwell_inc;
            end
            if (take_sample) begin
                result_channel <= cur;
                result_time    <= chk_failed[31] ? chk_failed[30:0] : '0;
                fail_mask[cur] <= fail_mask[cur] | chk_failed[31];
            end
        end
    end

    assign chk_hold           = !rst_n || state == IDLE || state == HOLD;
    assign busy               = rst_n && state != IDLE;
    assign chk_channel_select = cur;

endmodule

// File: tb/tb_tag_scan_sequencer.sv
// Randomized and directed bench for tag_scan_sequencer against a
// timeline model of each channel's settle/dwell/check/report phases.
module tb_tag_scan_sequencer;

    localparam int SETTLE = 8;
    localparam int CD     = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  chan_first = '0;
    logic [4:0]  chan_last = '0;
    logic [15:0] dwell_tags = '0;
    logic        valid_tag = 1'b0;
    logic [4:0]  channel = '0;
    logic [31:0] chk_failed = '0;
    logic        chk_hold;
    logic [4:0]  chk_channel_select;
    logic        busy;
    logic        done;
    logic [31:0] fail_mask;
    logic        result_valid;
    logic [4:0]  result_channel;
    logic [30:0] result_time;

    always #5 clk = ~clk;

    tag_scan_sequencer #(
        .SETTLE_CYCLES (SETTLE),
        .CHECK_DELAY   (CD)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .abort              (abort),
        .chan_first         (chan_first),
        .chan_last          (chan_last),
        .dwell_tags         (dwell_tags),
        .valid_tag          (valid_tag),
        .channel            (channel),
        .chk_failed         (chk_failed),
        .chk_hold           (chk_hold),
        .chk_channel_select (chk_channel_select),
        .busy               (busy),
        .done               (done),
        .fail_mask          (fail_mask),
        .result_valid       (result_valid),
        .result_channel     (result_channel),
        .result_time        (result_time)
    );

    // reference model: position within the current channel's timeline
    bit          m_init = 0;
    bit          m_act = 0;
    int          m_cur = 0;
    int          m_last = 0;
    int          m_tgt = 1;
    int          m_off = 0;
    int          m_tags = 0;
    int          m_dend = -1;
    logic        e_busy = 0;
    logic        e_done = 0;
    logic        e_hold = 1;
    logic        e_rv = 0;
    logic [4:0]  e_sel = 0;
    logic [4:0]  e_rch = 0;
    logic [30:0] e_rtime = 0;
    logic [31:0] e_mask = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_init = 1;
            m_act = 0;
            m_cur = 0;
            e_busy = 0;
            e_done = 0;
            e_hold = 1;
            e_rv = 0;
            e_sel = 0;
            e_rch = 0;
            e_rtime = 0;
            e_mask = 0;
        end else begin
            e_done = 0;
            e_rv = 0;
            if (!m_act) begin
                if (start && !abort) begin
                    if (chan_first <= chan_last) begin
                        m_act = 1;
                        m_cur = chan_first;
                        m_last = chan_last;
                        m_tgt = (dwell_tags == 0) ? 1 : int'(dwell_tags);
                        e_mask = 0;
                        m_off = 0;
                        m_tags = 0;
                        m_dend = -1;
                    end else begin
                        e_done = 1;
                        e_mask = 0;
                    end
                end
            end else if (abort) begin
                m_act = 0;
                e_done = 1;
            end else begin
                if (m_off < SETTLE) begin
                    m_tags = m_tags;
                end else if (m_dend < 0) begin
                    if (valid_tag && int'(channel) == m_cur) begin
                        m_tags++;
                        if (m_tags == m_tgt) m_dend = m_off;
                    end
                end else if (m_off == m_dend + CD) begin
                    e_rv = 1;
                    e_rch = 5'(m_cur);
                    e_rtime = chk_failed[31] ? chk_failed[30:0] : 31'd0;
                    if (chk_failed[31]) e_mask[m_cur] = 1'b1;
                end else if (m_off == m_dend + CD + 1) begin
                    if (m_cur == m_last) begin
                        m_act = 0;
                        e_done = 1;
                    end else begin
                        m_cur++;
                        m_off = -1;
                        m_tags = 0;
                        m_dend = -1;
                    end
                end
                m_off++;
            end
            e_busy = m_act;
            e_hold = !m_act || m_off < SETTLE;
            e_sel = 5'(m_cur);
        end
    end

    int checks = 0;
    int failures = 0;
    int tag_rate = 0;
    int alt_ch = -1;
    bit rnd_mode = 0;
    logic [31:0] chk_val = 0;
    int done_cnt = 0;
    int hold_n = 0;
    logic [4:0]  rv_ch[$];
    logic [30:0] rv_tm[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures < 40)
                $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        if (!m_init) return;
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("chk_hold", chk_hold, e_hold);
        chk("chk_sel", chk_channel_select, e_sel);
        chk("fail_mask", fail_mask, e_mask);
        chk("result_valid", result_valid, e_rv);
        chk("result_channel", result_channel, e_rch);
        chk("result_time", result_time, e_rtime);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        compare();
        if (done) done_cnt++;
        if (busy && chk_hold) hold_n++;
        if (result_valid) begin
            rv_ch.push_back(result_channel);
            rv_tm.push_back(result_time);
        end
        start = 0;
        abort = 0;
        valid_tag = ($urandom_range(99) < tag_rate);
        if ($urandom_range(1) == 1) channel = 5'(m_cur);
        else if (alt_ch < 0) channel = 5'($urandom_range(31));
        else channel = 5'(alt_ch);
        chk_failed = chk_val;
        if (rnd_mode) begin
            chk_failed = $urandom();
            dwell_tags = 16'($urandom_range(4));
            if (m_act && $urandom_range(149) == 0) abort = 1;
            if (m_act && $urandom_range(49) == 0) begin
                start = 1;
                chan_first = 5'($urandom_range(31));
                chan_last = 5'($urandom_range(31));
            end
        end
    endtask

    task automatic pulse_start(int f, int l, int d);
        cyc();
        chan_first = 5'(f);
        chan_last = 5'(l);
        dwell_tags = 16'(d);
        start = 1;
    endtask

    task automatic wait_done(int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        int d0;
        int r0;
        int h0;
        int rv_off;
        int f;
        int l;

        repeat (3) cyc();
        chk("rst_busy", busy, 0);
        chk("rst_hold", chk_hold, 1);
        chk("rst_mask", fail_mask, 0);
        chk("rst_rch", result_channel, 0);
        rst_n = 1;
        repeat (2) cyc();

        // ch 0..1, dwell 4, no failure
        tag_rate = 60;
        alt_ch = -1;
        chk_val = 0;
        d0 = done_cnt;
        r0 = rv_ch.size();
        h0 = hold_n;
        pulse_start(0, 1, 4);
        wait_done(300);
        chk("s1_nres", rv_ch.size() - r0, 2);
        if (rv_ch.size() >= r0 + 2) begin
            chk("s1_ch0", rv_ch[r0], 0);
            chk("s1_ch1", rv_ch[r0 + 1], 1);
            chk("s1_t0", rv_tm[r0], 0);
        end
        chk("s1_mask", fail_mask, 0);
        chk("s1_done", done_cnt - d0, 1);
        chk("s1_hold", hold_n - h0, 2 * SETTLE);

        // ch 2..2 with a latched failure
        chk_val = 32'h8000_1234;
        r0 = rv_ch.size();
        pulse_start(2, 2, 3);
        wait_done(300);
        chk("s2_nres", rv_ch.size() - r0, 1);
        if (rv_ch.size() > r0) begin
            chk("s2_ch", rv_ch[r0], 2);
            chk("s2_time", rv_tm[r0], 31'h1234);
        end
        chk("s2_mask", fail_mask, 32'h0000_0004);

        // ch 5 only, ch4 tags interleaved
        chk_val = 0;
        tag_rate = 0;
        rv_off = -1;
        pulse_start(5, 5, 2);
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (result_valid && rv_off < 0) rv_off = k - 1;
            if (k - 1 == 3) begin valid_tag = 1; channel = 5; end
            if (k - 1 == 8) begin valid_tag = 1; channel = 4; end
            if (k - 1 == 9) begin valid_tag = 1; channel = 5; end
            if (k - 1 == 10) begin valid_tag = 1; channel = 4; end
            if (k - 1 == 11) begin valid_tag = 1; channel = 4; end
            if (k - 1 == 12) begin valid_tag = 1; channel = 5; end
        end
        chk("s3_rv_off", rv_off, 15);
        wait_done(50);

        // ch 30..31, no wrap
        tag_rate = 60;
        chk_val = 32'h8000_0005;
        d0 = done_cnt;
        r0 = rv_ch.size();
        pulse_start(30, 31, 2);
        wait_done(300);
        repeat (30) cyc();
        chk("s4_nres", rv_ch.size() - r0, 2);
        if (rv_ch.size() >= r0 + 2) begin
            chk("s4_ch30", rv_ch[r0], 30);
            chk("s4_ch31", rv_ch[r0 + 1], 31);
        end
        chk("s4_done", done_cnt - d0, 1);
        chk("s4_mask", fail_mask, 32'hC000_0000);

        // empty range
        d0 = done_cnt;
        r0 = rv_ch.size();
        h0 = hold_n;
        pulse_start(7, 3, 2);
        cyc();
        chk("s5_done", done, 1);
        chk("s5_busy", busy, 0);
        cyc();
        chk("s5_done_off", done, 0);
        chk("s5_mask", fail_mask, 0);
        repeat (5) cyc();
        chk("s5_ndone", done_cnt - d0, 1);
        chk("s5_nres", rv_ch.size() - r0, 0);
        chk("s5_nhold", hold_n - h0, 0);

        // abort in dwell of second channel
        tag_rate = 70;
        chk_val = 32'h8000_0077;
        d0 = done_cnt;
        r0 = rv_ch.size();
        pulse_start(10, 12, 3);
        for (int i = 0; i < 200 && rv_ch.size() == r0; i++) cyc();
        chk("s6_first", rv_ch.size() - r0, 1);
        tag_rate = 0;
        repeat (10) cyc();
        abort = 1;
        cyc();
        chk("s6_done", done, 1);
        chk("s6_hold", chk_hold, 1);
        chk("s6_busy", busy, 0);
        repeat (10) cyc();
        chk("s6_nres", rv_ch.size() - r0, 1);
        chk("s6_mask", fail_mask, 32'h0000_0400);
        chk("s6_ndone", done_cnt - d0, 1);

        // start and abort together while idle
        d0 = done_cnt;
        r0 = rv_ch.size();
        h0 = hold_n;
        cyc();
        chan_first = 0;
        chan_last = 3;
        start = 1;
        abort = 1;
        repeat (12) cyc();
        chk("s7_ndone", done_cnt - d0, 0);
        chk("s7_nres", rv_ch.size() - r0, 0);
        chk("s7_nhold", hold_n - h0, 0);

        // reset mid-scan
        tag_rate = 60;
        chk_val = 0;
        pulse_start(0, 3, 2);
        repeat (15) cyc();
        d0 = done_cnt;
        rst_n = 0;
        repeat (2) cyc();
        rst_n = 1;
        repeat (5) cyc();
        chk("s8_ndone", done_cnt - d0, 0);
        chk("s8_mask", fail_mask, 0);
        chk("s8_sel", chk_channel_select, 0);

        // randomized scans
        rnd_mode = 1;
        for (int it = 0; it < 30; it++) begin
            f = $urandom_range(31);
            l = f + $urandom_range(3);
            if (l > 31) l = 31;
            if ($urandom_range(7) == 0 && f > 0) l = f - 1;
            tag_rate = 30 + $urandom_range(60);
            pulse_start(f, l, $urandom_range(4));
            d0 = done_cnt;
            wait_done(1000);
            chk("rand_done", (done_cnt != d0) ? 1 : 0, 1);
            repeat ($urandom_range(3)) cyc();
        end
        rnd_mode = 0;
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
